parallel_to_serial: RTL and testbench
=====================================

PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 Parameter: DATA_LENGTH, default 10, word width in bits; legal range >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 parallel_in  input  DATA_LENGTH  word to serialize; sampled only on load handshake.
REQ-005 load_valid  input  1  producer offers parallel_in.
REQ-006 load_ready  output  1  block can accept a word.
REQ-007 shift_dir  input  1  0 = MSB first (shift left), 1 = LSB first (shift right); sampled only on load handshake.
REQ-008 bit_enable  input  1  bit-rate strobe; current bit is consumed on a rising edge only when high.
REQ-009 serial_out  output  1  current serial bit.
REQ-010 serial_valid  output  1  serial_out carries a valid data bit.
REQ-011 busy  output  1  word in progress.
REQ-012 done  output  1  one-cycle pulse after the last bit of a word is consumed.

Function
REQ-013 The block SHALL implement the FSM states IDLE and SHIFT, plus a DATA_LENGTH-bit shift register, a latched direction bit and a bit counter of width $clog2(DATA_LENGTH).
REQ-014 IDLE: load_ready=1, busy=0, serial_valid=0, serial_out=0.
REQ-015 A load handshake (load_valid=1 and load_ready=1 at a rising edge) SHALL capture parallel_in and shift_dir, set counter to DATA_LENGTH-1, and move the FSM to SHIFT.
REQ-016 SHIFT: load_ready=0, busy=1, serial_valid=1.
REQ-017 serial_out in SHIFT SHALL be the register MSB when the latched direction is 0 and the LSB when it is 1, with zero combinational dependence on the inputs.
REQ-018 The first bit SHALL appear in the cycle immediately after the handshake.
REQ-019 In SHIFT with bit_enable=1 and counter>0, the block SHALL shift one position (left for dir 0, right for dir 1), zero-fill, and decrement the counter.
REQ-020 In SHIFT with bit_enable=1 and counter=0, the block SHALL return to IDLE and register done=1 for exactly the next cycle.
REQ-021 In SHIFT with bit_enable=0, the register, counter and serial_out SHALL hold, so each bit persists until it is consumed.
REQ-022 load_valid during SHIFT SHALL be ignored; no capture, no state change.
REQ-023 Changes to shift_dir or parallel_in during SHIFT SHALL have no effect on the word in progress.
REQ-024 Back-to-back: the done cycle is an IDLE cycle with load_ready=1, so a new handshake may coincide with done, giving exactly one idle cycle between words.
REQ-025 With bit_enable held high, a word SHALL occupy DATA_LENGTH consecutive cycles of serial_valid=1.

Reset
REQ-026 On rst=1, asynchronously and at any time including mid-word, the block SHALL enter IDLE with register=0, counter=0, latched direction=0 and done=0.
REQ-027 The reset outputs SHALL be load_ready=1, busy=0, serial_valid=0, serial_out=0; a word in progress is discarded and no done pulse is produced.
REQ-028 After rst deasserts, the first handshake SHALL be accepted on the first rising edge.

Verification (DATA_LENGTH=10)
REQ-029 Assert rst between edges -> outputs immediately load_ready=1, busy=0, serial_valid=0, serial_out=0, done=0.
REQ-030 Load 10'b1011001110 with shift_dir=0 and bit_enable=1 -> serial_out 1,0,1,1,0,0,1,1,1,0 on cycles 1..10 after the handshake; done=1 on cycle 11 only.
REQ-031 Same word with shift_dir=1 -> serial_out 0,1,1,1,0,0,1,1,0,1; done on cycle 11.
REQ-032 bit_enable high every 3rd cycle, load_valid=1 with a different word throughout SHIFT -> each bit held 3 cycles; the second word is not captured before done.
REQ-033 rst pulsed after the 4th bit of 10'h3FF -> serial_out=0 and busy=0 at once, no done pulse; a new load after release starts at bit 1.
REQ-034 load_valid held high with words 10'h2AA then 10'h155 and bit_enable=1 -> 10 bits, one cycle with done=1 and the handshake accepted, then 10 bits of the second word.

Source files
------------

// File: rtl/parallel_to_serial.sv
// Word serializer: loads a DATA_LENGTH-bit word on a ready/valid handshake and
// shifts it out one bit per bit_enable strobe, MSB- or LSB-first.
module parallel_to_serial #(
  parameter int DATA_LENGTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_LENGTH-1:0] parallel_in,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic                   shift_dir,
  input  logic                   bit_enable,
  output logic                   serial_out,
  output logic                   serial_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = $clog2(DATA_LENGTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LENGTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [DATA_LENGTH-1:0]   shreg;
  logic                     dir;
  logic [CNT_W-1:0]         cnt;
  logic                     load_hs;
  logic                     consume;
  logic                     bit_last;

  assign load_hs  = load_valid && (state == IDLE);
  assign consume  = bit_enable && (state == SHIFT);
  assign bit_last = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_valid)              state_next = SHIFT;
      SHIFT:   if (bit_enable && bit_last)  state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  // Outputs depend only on registered state so serial_out never glitches with inputs.
  always_comb begin
    load_ready   = 1'b0;
    busy         = 1'b0;
    serial_valid = 1'b0;
    serial_out   = 1'b0;
    case (state)
      IDLE:  load_ready = 1'b1;
      SHIFT: begin
        busy         = 1'b1;
        serial_valid = 1'b1;
        serial_out   = dir ? shreg[0] : shreg[DATA_LENGTH-1];
      end
      default: load_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      dir   <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= consume && bit_last;
      if (load_hs) begin
        shreg <= parallel_in;
        dir   <= shift_dir;
        cnt   <= CNT_LAST;
      end else if (consume && !bit_last) begin
        shreg <= dir ? {1'b0, shreg[DATA_LENGTH-1:1]} : {shreg[DATA_LENGTH-2:0], 1'b0};
        cnt   <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial with DATA_LENGTH=10.
module tb_parallel_to_serial;

  localparam int DL = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DL-1:0] parallel_in = '0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic          shift_dir = 1'b0;
  logic          bit_enable = 1'b0;
  logic          serial_out;
  logic          serial_valid;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  parallel_to_serial #(.DATA_LENGTH(DL)) dut (
    .clk          (clk),
    .rst          (rst),
    .parallel_in  (parallel_in),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .shift_dir    (shift_dir),
    .bit_enable   (bit_enable),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, actual running required finished");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    checks += 5;
    if (load_ready !== 1'b1)   begin errors++; $display("FAIL reset_load_ready: got %b expected 1", load_ready); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (serial_valid !== 1'b0) begin errors++; $display("FAIL reset_serial_valid: got %b expected 0", serial_valid); end
    if (serial_out !== 1'b0)   begin errors++; $display("FAIL reset_serial_out: got %b expected 0", serial_out); end
    if (done !== 1'b0)         begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  // seq holds the expected output bits, first-transmitted bit in seq[9].
  task automatic test_direction(input logic [DL-1:0] word, input logic dir, input logic [DL-1:0] seq);
    parallel_in = word;
    shift_dir   = dir;
    bit_enable  = 1'b1;
    load_valid  = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < DL; i++) begin
      checks += 3;
      if (serial_out !== seq[DL-1-i]) begin errors++; $display("FAIL dir%0d_bit%0d: got %b expected %b", dir, i + 1, serial_out, seq[DL-1-i]); end
      if (serial_valid !== 1'b1)      begin errors++; $display("FAIL dir%0d_valid%0d: got %b expected 1", dir, i + 1, serial_valid); end
      if (done !== 1'b0)              begin errors++; $display("FAIL dir%0d_early_done%0d: got %b expected 0", dir, i + 1, done); end
      shift_dir   = ~shift_dir;
      parallel_in = ~parallel_in;
      tick();
    end
    checks += 4;
    if (done !== 1'b1)         begin errors++; $display("FAIL dir%0d_done: got %b expected 1", dir, done); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL dir%0d_done_busy: got %b expected 0", dir, busy); end
    if (serial_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_done_valid: got %b expected 0", dir, serial_valid); end
    tick();
    if (done !== 1'b0)         begin errors++; $display("FAIL dir%0d_done_pulse: got %b expected 0", dir, done); end
  endtask

  task automatic test_held_bits;
    logic [DL-1:0] word;
    int idx;
    int c;
    logic be;
    word        = 10'b1100101001;
    parallel_in = word;
    shift_dir   = 1'b0;
    bit_enable  = 1'b0;
    load_valid  = 1'b1;
    tick();
    parallel_in = 10'h3FF;
    idx = 0;
    c   = 0;
    while (idx < DL && c < 40) begin
      checks += 3;
      if (serial_out !== word[DL-1-idx]) begin errors++; $display("FAIL held_bit%0d_cyc%0d: got %b expected %b", idx + 1, c, serial_out, word[DL-1-idx]); end
      if (busy !== 1'b1)                 begin errors++; $display("FAIL held_busy_cyc%0d: got %b expected 1", c, busy); end
      if (done !== 1'b0)                 begin errors++; $display("FAIL held_done_cyc%0d: got %b expected 0", c, done); end
      be = (c % 3 == 2);
      bit_enable = be;
      c++;
      tick();
      if (be) idx++;
    end
    checks += 4;
    if (c !== 30)            begin errors++; $display("FAIL held_cycles: got %0d expected 30", c); end
    if (done !== 1'b1)       begin errors++; $display("FAIL held_done: got %b expected 1", done); end
    if (load_ready !== 1'b1) begin errors++; $display("FAIL held_ready: got %b expected 1", load_ready); end
    load_valid = 1'b0;
    bit_enable = 1'b0;
    tick();
    if (busy !== 1'b0)       begin errors++; $display("FAIL held_no_capture: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_word;
    logic [DL-1:0] word2;
    word2       = 10'b1000000001;
    parallel_in = 10'h3FF;
    shift_dir   = 1'b0;
    bit_enable  = 1'b1;
    load_valid  = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (serial_out !== 1'b0)   begin errors++; $display("FAIL midrst_serial_out: got %b expected 0", serial_out); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (serial_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", serial_valid); end
    if (load_ready !== 1'b1)   begin errors++; $display("FAIL midrst_ready: got %b expected 1", load_ready); end
    if (done !== 1'b0)         begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    parallel_in = word2;
    load_valid  = 1'b1;
    #1 rst = 1'b0;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < DL; i++) begin
      checks += 3;
      if (busy !== 1'b1)               begin errors++; $display("FAIL postrst_busy%0d: got %b expected 1", i + 1, busy); end
      if (serial_out !== word2[DL-1-i]) begin errors++; $display("FAIL postrst_bit%0d: got %b expected %b", i + 1, serial_out, word2[DL-1-i]); end
      if (done !== 1'b0)               begin errors++; $display("FAIL postrst_done%0d: got %b expected 0", i + 1, done); end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL postrst_final_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [DL-1:0] w1;
    logic [DL-1:0] w2;
    w1          = 10'h2AA;
    w2          = 10'h155;
    parallel_in = w1;
    shift_dir   = 1'b0;
    bit_enable  = 1'b1;
    load_valid  = 1'b1;
    tick();
    parallel_in = w2;
    for (int i = 0; i < DL; i++) begin
      checks += 2;
      if (serial_out !== w1[DL-1-i]) begin errors++; $display("FAIL b2b_w1_bit%0d: got %b expected %b", i + 1, serial_out, w1[DL-1-i]); end
      if (serial_valid !== 1'b1)     begin errors++; $display("FAIL b2b_w1_valid%0d: got %b expected 1", i + 1, serial_valid); end
      tick();
    end
    checks += 3;
    if (done !== 1'b1)         begin errors++; $display("FAIL b2b_done1: got %b expected 1", done); end
    if (load_ready !== 1'b1)   begin errors++; $display("FAIL b2b_ready: got %b expected 1", load_ready); end
    if (serial_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap_valid: got %b expected 0", serial_valid); end
    tick();
    for (int i = 0; i < DL; i++) begin
      checks += 2;
      if (serial_out !== w2[DL-1-i]) begin errors++; $display("FAIL b2b_w2_bit%0d: got %b expected %b", i + 1, serial_out, w2[DL-1-i]); end
      if (serial_valid !== 1'b1)     begin errors++; $display("FAIL b2b_w2_valid%0d: got %b expected 1", i + 1, serial_valid); end
      load_valid = 1'b0;
      tick();
    end
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b expected 1", done); end
    tick();
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_done2_pulse: got %b expected 0", done); end
  endtask

  initial begin
    test_reset();
    test_direction(10'b1011001110, 1'b0, 10'b1011001110);
    test_direction(10'b1011001110, 1'b1, 10'b0111001101);
    test_held_bits();
    test_reset_mid_word();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
